// File: rtl/pw_pkg.sv
// Shared types and constants for the pointwise tile sequencer: FSM states,
// channel-group width, layer-band bias/shift tables and the result tag record.
package pw_pkg;

    localparam int CH_GRP = 8;

    localparam int LAYER_BAND0 = 4;
    localparam int LAYER_BAND1 = 8;

    localparam logic [7:0] BIAS_BASE0 = 8'd0;
    localparam logic [7:0] BIAS_BASE1 = 8'd32;
    localparam logic [7:0] BIAS_BASE2 = 8'd64;

    localparam logic [3:0] SHIFT0 = 4'd6;
    localparam logic [3:0] SHIFT1 = 4'd7;
    localparam logic [3:0] SHIFT2 = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [7:0] h;
        logic [7:0] w;
        logic [7:0] oc_sel;
    } tag_t;

    function automatic logic [7:0] bias_for_layer(input logic [3:0] layer);
        if (int'(layer) < LAYER_BAND0) return BIAS_BASE0;
        if (int'(layer) < LAYER_BAND1) return BIAS_BASE1;
        return BIAS_BASE2;
    endfunction

    function automatic logic [3:0] shift_for_layer(input logic [3:0] layer);
        if (int'(layer) < LAYER_BAND0) return SHIFT0;
        if (int'(layer) < LAYER_BAND1) return SHIFT1;
        return SHIFT2;
    endfunction

endpackage

// File: rtl/pw_tag_pipe.sv
// Fixed-depth shift register that delays tile tags so they line up with the
// compute array's results.
module pw_tag_pipe
    import pw_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/pw_tile_sequencer.sv
// Walks (h, w, oc group, ic group) tiles of one pointwise layer, one per cycle,
// and realigns tile tags to the array latency. Optional PW_SEQ_PERF_EN adds perf counters.
module pw_tile_sequencer #(
    parameter int PIPE_LAT = 3,
    parameter int CH_GRP   = pw_pkg::CH_GRP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cfg_layer,
    input  logic [7:0]  cfg_out_size,
    input  logic [7:0]  cfg_in_ch,
    input  logic [7:0]  cfg_out_ch,
    input  logic        feat_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
`ifdef PW_SEQ_PERF_EN
    output logic [31:0] perf_active,
    output logic [31:0] perf_stall,
`endif
    output logic        issue_valid,
    output logic [7:0]  iss_h,
    output logic [7:0]  iss_w,
    output logic [7:0]  iss_ic_sel,
    output logic [7:0]  iss_oc_sel,
    output logic        pix_adv,
    output logic [7:0]  bias_base,
    output logic [3:0]  shift_num,
    output logic        res_valid,
    output logic        res_first_ic,
    output logic        res_last_ic,
    output logic [7:0]  res_h,
    output logic [7:0]  res_w,
    output logic [7:0]  res_oc_sel
);

    import pw_pkg::*;

    state_t     state;
    logic [7:0] size_q, n_ic, n_oc;
    logic [7:0] n_ic_calc, n_oc_calc, last_ic_sel, last_oc_sel;
    logic [3:0] inflight, inflight_next;
    logic       issue, last_ic, last_oc, last_w, last_h, final_tile, cfg_zero;
    tag_t       tag_in, tag_out;

    assign n_ic_calc   = 8'((int'(cfg_in_ch) + CH_GRP - 1) / CH_GRP);
    assign n_oc_calc   = 8'((int'(cfg_out_ch) + CH_GRP - 1) / CH_GRP);
    assign last_ic_sel = 8'((int'(n_ic) - 1) * CH_GRP);
    assign last_oc_sel = 8'((int'(n_oc) - 1) * CH_GRP);
    assign cfg_zero    = (cfg_out_size == 8'd0) || (cfg_in_ch == 8'd0) || (cfg_out_ch == 8'd0);

    assign issue      = (state == RUN) && feat_valid && out_ready;
    assign last_ic    = (iss_ic_sel == last_ic_sel);
    assign last_oc    = (iss_oc_sel == last_oc_sel);
    assign last_w     = (iss_w == size_q - 8'd1);
    assign last_h     = (iss_h == size_q - 8'd1);
    assign final_tile = last_ic && last_oc && last_w && last_h;

    assign issue_valid = issue;
    assign pix_adv     = issue && last_ic && last_oc;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // Results leave the array regardless of stalls, so the count only balances issue vs result.
    always_comb begin
        inflight_next = inflight;
        if (issue && !tag_out.valid)      inflight_next = inflight + 4'd1;
        else if (!issue && tag_out.valid) inflight_next = inflight - 4'd1;
    end

    always_comb begin
        tag_in = '0;
        if (issue) begin
            tag_in.valid  = 1'b1;
            tag_in.first  = (iss_ic_sel == 8'd0);
            tag_in.last   = last_ic;
            tag_in.h      = iss_h;
            tag_in.w      = iss_w;
            tag_in.oc_sel = iss_oc_sel;
        end
    end

    pw_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign res_valid    = tag_out.valid;
    assign res_first_ic = tag_out.first;
    assign res_last_ic  = tag_out.last;
    assign res_h        = tag_out.h;
    assign res_w        = tag_out.w;
    assign res_oc_sel   = tag_out.oc_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            size_q     <= '0;
            n_ic       <= '0;
            n_oc       <= '0;
            bias_base  <= '0;
            shift_num  <= '0;
            iss_h      <= '0;
            iss_w      <= '0;
            iss_ic_sel <= '0;
            iss_oc_sel <= '0;
            inflight   <= '0;
        end else begin
            inflight <= inflight_next;
            case (state)
                IDLE: if (start) begin
                    size_q     <= cfg_out_size;
                    n_ic       <= n_ic_calc;
                    n_oc       <= n_oc_calc;
                    bias_base  <= bias_for_layer(cfg_layer);
                    shift_num  <= shift_for_layer(cfg_layer);
                    iss_h      <= '0;
                    iss_w      <= '0;
                    iss_ic_sel <= '0;
                    iss_oc_sel <= '0;
                    state      <= cfg_zero ? DONE : RUN;
                end
                // ic is innermost; each wrap carries into the next outer counter.
                RUN: if (issue) begin
                    if (!last_ic) begin
                        iss_ic_sel <= iss_ic_sel + 8'(CH_GRP);
                    end else begin
                        iss_ic_sel <= '0;
                        if (!last_oc) begin
                            iss_oc_sel <= iss_oc_sel + 8'(CH_GRP);
                        end else begin
                            iss_oc_sel <= '0;
                            if (!last_w) begin
                                iss_w <= iss_w + 8'd1;
                            end else begin
                                iss_w <= '0;
                                iss_h <= last_h ? 8'd0 : iss_h + 8'd1;
                            end
                        end
                    end
                    if (final_tile) state <= DRAIN;
                end
                DRAIN: if (inflight_next == 4'd0) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PW_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_active <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && start) begin
            perf_active <= '0;
            perf_stall  <= '0;
        end else begin
            if ((state == RUN || state == DRAIN) && perf_active != '1) perf_active <= perf_active + 32'd1;
            if (state == RUN && !issue && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
